interrupt_register: RTL and testbench

Status and pending-interrupt register between the board's four slide switches and North push button and the processor's interrupt logic. It synchronizes the asynchronous board inputs. It keeps a processor-loadable snapshot of the switch levels. It latches a sticky pending flag on each North button press, which software can clear or set by writing it.

---
 rtl/interrupt_register_pkg.sv | 10 +
 rtl/sync_bit.sv | 32 +++
 rtl/interrupt_register.sv | 91 +++++++++
 tb/tb_interrupt_register.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_register_pkg.sv
// rtl/interrupt_register_pkg.sv - shared constants for the interrupt/status register
package interrupt_register_pkg;

    // Synchronizer depth used when the instantiating level does not override it
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Number of slide switches captured into the switch snapshot
    localparam int NUM_SWITCHES = 4;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - parameterized 1-bit synchronizer with synchronous clear
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    if (STAGES == 0) begin : g_bypass
        // Depth 0: the input is already in the clock domain, pass it straight through
        assign q = d;
    end else begin : g_chain
        logic [STAGES-1:0] chain;

        // Shift the raw level through the flop chain; clear drops every stage to 0
        always_ff @(posedge clk) begin
            if (clr) begin
                chain <= '0;
            end else begin
                chain[0] <= d;
                for (int i = 1; i < STAGES; i++) begin
                    chain[i] <= chain[i-1];
                end
            end
        end

        assign q = chain[STAGES-1];
    end

endmodule

// File: rtl/interrupt_register.sv
// rtl/interrupt_register.sv - switch snapshot and sticky North-button pending flag
module interrupt_register
    import interrupt_register_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic CLK,
    input  logic CLR,
    input  logic Sw0,
    input  logic Sw1,
    input  logic Sw2,
    input  logic Sw3,
    input  logic Write,
    input  logic North_Button,
    input  logic North_Button_Data,
    input  logic North_Button_Write,
    output logic Sw0_State,
    output logic Sw1_State,
    output logic Sw2_State,
    output logic Sw3_State,
    output logic North_Button_State
);

    logic [NUM_SWITCHES-1:0] sw_raw;
    logic [NUM_SWITCHES-1:0] sw_s;
    logic [NUM_SWITCHES-1:0] sw_state;
    logic                    nb_s;
    logic                    nb_prev;
    logic                    nb_rise;
    logic                    nb_pending;

    assign sw_raw = {Sw3, Sw2, Sw1, Sw0};

    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw_sync
        sync_bit #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk (CLK),
            .clr (CLR),
            .d   (sw_raw[i]),
            .q   (sw_s[i])
        );
    end

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_nb_sync (
        .clk (CLK),
        .clr (CLR),
        .d   (North_Button),
        .q   (nb_s)
    );

    // Snapshot the synchronized switch levels whenever the processor strobes Write
    always_ff @(posedge CLK) begin
        if (CLR) begin
            sw_state <= '0;
        end else if (Write) begin
            sw_state <= sw_s;
        end
    end

    // Remember the previous button level; restarting at 0 makes a held button fire once after reset
    always_ff @(posedge CLK) begin
        if (CLR) begin
            nb_prev <= 1'b0;
        end else begin
            nb_prev <= nb_s;
        end
    end

    assign nb_rise = nb_s & ~nb_prev;

    // Sticky pending flag: a press outranks a software write so no interrupt is dropped
    always_ff @(posedge CLK) begin
        if (CLR) begin
            nb_pending <= 1'b0;
        end else if (nb_rise) begin
            nb_pending <= 1'b1;
        end else if (North_Button_Write) begin
            nb_pending <= North_Button_Data;
        end
    end

    assign Sw0_State          = sw_state[0];
    assign Sw1_State          = sw_state[1];
    assign Sw2_State          = sw_state[2];
    assign Sw3_State          = sw_state[3];
    assign North_Button_State = nb_pending;

endmodule

// File: tb/tb_interrupt_register.sv
// tb/tb_interrupt_register.sv - scoreboard bench for interrupt_register
module tb_interrupt_register;

    localparam int S = 2;
    localparam int L = S + 1;

    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [4:0] M_SW  = 5'b01111;
    localparam logic [4:0] M_NB  = 5'b10000;

    typedef struct {
        int         cyc;
        logic [4:0] val;
        logic [4:0] mask;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] sw;
    logic       wr;
    logic       nb;
    logic       nb_data;
    logic       nb_wr;
    logic       sw0_st, sw1_st, sw2_st, sw3_st, nb_st;

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    exp_t sb[$];

    interrupt_register #(
        .SYNC_STAGES (S)
    ) dut (
        .CLK                (clk),
        .CLR                (clr),
        .Sw0                (sw[0]),
        .Sw1                (sw[1]),
        .Sw2                (sw[2]),
        .Sw3                (sw[3]),
        .Write              (wr),
        .North_Button       (nb),
        .North_Button_Data  (nb_data),
        .North_Button_Write (nb_wr),
        .Sw0_State          (sw0_st),
        .Sw1_State          (sw1_st),
        .Sw2_State          (sw2_st),
        .Sw3_State          (sw3_st),
        .North_Button_State (nb_st)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue an expected output value for the given number of edges from now, kept sorted by cycle
    task automatic expect_in(input int k, input string name, input logic [4:0] val, input logic [4:0] mask);
        exp_t e;
        int   idx;
        e.cyc  = cyc + k;
        e.val  = val;
        e.mask = mask;
        e.name = name;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: on every falling edge, compare outputs against entries due this cycle
    always @(negedge clk) begin
        logic [4:0] outs;
        exp_t       e;
        outs = {nb_st, sw3_st, sw2_st, sw1_st, sw0_st};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc < cyc) begin
                $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if ((outs & e.mask) !== (e.val & e.mask)) begin
                $display("FAIL %s: cycle %0d got %b expected %b (mask %b)", e.name, cyc, outs, e.val, e.mask);
            end else begin
                passed++;
            end
        end
    end

    initial begin
        // 1. reset with every input high, then release with the button still held
        clr = 1'b1; sw = 4'b1111; wr = 1'b1; nb = 1'b1; nb_data = 1'b1; nb_wr = 1'b1;
        expect_in(1, "reset_edge1", 5'b00000, M_ALL);
        expect_in(2, "reset_edge2", 5'b00000, M_ALL);
        tick(2);
        clr = 1'b0; wr = 1'b0; nb_wr = 1'b0; nb_data = 1'b0; sw = 4'b0000;
        expect_in(L - 1, "held_after_reset_early", 5'b00000, M_ALL);
        expect_in(L,     "held_after_reset_event", 5'b10000, M_ALL);
        expect_in(L + 2, "held_after_reset_once",  5'b10000, M_ALL);
        tick(L + 2);

        // 2. switch load with Write held high
        wr = 1'b1; sw = 4'b1111;
        expect_in(L - 1, "load_1111_early", 5'b00000, M_SW);
        expect_in(L,     "load_1111",       5'b01111, M_SW);
        tick(L);
        sw = 4'b1010;
        expect_in(L - 1, "load_1010_early", 5'b01111, M_SW);
        expect_in(L,     "load_1010",       5'b01010, M_SW);
        tick(L + 1);

        // 3. switch hold with Write low, then a single-cycle Write pulse
        wr = 1'b0; sw = 4'b0101;
        expect_in(1,     "hold_1010_a", 5'b01010, M_SW);
        expect_in(L + 3, "hold_1010_b", 5'b01010, M_SW);
        tick(L + 3);
        wr = 1'b1;
        expect_in(1, "pulse_load_0101", 5'b00101, M_SW);
        tick(1);
        wr = 1'b0; sw = 4'b0000;
        expect_in(L + 2, "hold_0101", 5'b00101, M_SW);
        tick(L + 2);

        // 4. pending set once by a 3-cycle press, then cleared and set by writes
        nb = 1'b0; nb_wr = 1'b1; nb_data = 1'b0;
        expect_in(1, "clear_before_press", 5'b00000, M_NB);
        tick(1);
        nb_wr = 1'b0;
        tick(L + 1);
        nb = 1'b1;
        expect_in(L - 1, "press_early", 5'b00000, M_NB);
        expect_in(L,     "press_set",   5'b10000, M_NB);
        tick(3);
        nb = 1'b0;
        expect_in(1,     "press_sticky", 5'b10000, M_NB);
        expect_in(L + 1, "release_no_event", 5'b10000, M_NB);
        tick(L + 2);
        nb_wr = 1'b1; nb_data = 1'b0;
        expect_in(1, "write_clear", 5'b00000, M_NB);
        tick(1);
        nb_data = 1'b1;
        expect_in(1, "write_set", 5'b10000, M_NB);
        tick(1);
        nb_wr = 1'b0;

        // 5. collision: press event and a write of 0 on the same edge
        nb_wr = 1'b1; nb_data = 1'b0;
        expect_in(1, "collide_pre_clear", 5'b00000, M_NB);
        tick(1);
        nb_wr = 1'b0;
        nb = 1'b1;
        expect_in(L,     "collide_press_wins", 5'b10000, M_NB);
        expect_in(L + 1, "collide_press_held", 5'b10000, M_NB);
        tick(L - 1);
        nb_wr = 1'b1; nb_data = 1'b0;
        tick(1);
        nb_wr = 1'b0;
        tick(1);
        nb = 1'b0; nb_wr = 1'b1; nb_data = 1'b0;
        expect_in(1, "collide2_pre_clear", 5'b00000, M_NB);
        tick(1);
        nb_wr = 1'b0;
        tick(L + 1);
        // same collision, now with CLR on that edge; the held button fires again after reset
        nb = 1'b1;
        expect_in(L,     "collide_clr_wins",    5'b00000, M_ALL);
        expect_in(2 * L - 1, "post_clr_early",  5'b00000, M_NB);
        expect_in(2 * L, "post_clr_event",      5'b10000, M_NB);
        tick(L - 1);
        nb_wr = 1'b1; nb_data = 1'b0; clr = 1'b1;
        tick(1);
        nb_wr = 1'b0; clr = 1'b0;
        tick(L);

        // 6. level hold: clearing while held does not re-trigger until release and re-press
        nb_wr = 1'b1; nb_data = 1'b0;
        expect_in(1, "level_clear", 5'b00000, M_NB);
        tick(1);
        nb_wr = 1'b0;
        expect_in(5, "level_no_retrigger", 5'b00000, M_NB);
        tick(5);
        nb = 1'b0;
        expect_in(L + 1, "level_release", 5'b00000, M_NB);
        tick(L + 1);
        nb = 1'b1;
        expect_in(L, "level_repress", 5'b10000, M_NB);
        tick(L + 2);

        #1;
        total++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
